serial_alu_sched: RTL and testbench

//  Shares one bit-serial add/subtract datapath between two requesters.

---
 rtl/serial_alu_pkg.sv | 13 +
 rtl/serial_addsub_dp.sv | 55 +++++
 rtl/serial_alu_sched.sv | 108 ++++++++++
 tb/tb_serial_alu_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// rtl/serial_alu_pkg.sv - shared encodings for the serial add/subtract scheduler
package serial_alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_dp.sv
// rtl/serial_addsub_dp.sv - bit-serial add/subtract datapath, LSB first
module serial_addsub_dp
  import serial_alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Load,
  input  logic         Shift,
  input  logic         OpSub,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Result,
  output logic         CarryOut,
  output logic         Overflow
);

  logic [N-1:0] a_sr;
  logic [N-1:0] b_sr;
  logic [N-1:0] r_sr;
  logic         carry;
  logic         cin_msb;
  logic         sum;

  assign sum = a_sr[0] ^ b_sr[0] ^ carry;

  // Load operands (B inverted, carry preset for subtract), then shift one bit per edge.
  // cin_msb follows the carry into each stage, so after the last shift it holds the
  // carry into the MSB and stops changing once shifting ends.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      a_sr    <= '0;
      b_sr    <= '0;
      r_sr    <= '0;
      carry   <= 1'b0;
      cin_msb <= 1'b0;
    end else if (Load) begin
      a_sr  <= A;
      b_sr  <= OpSub ? ~B : B;
      carry <= OpSub;
    end else if (Shift) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      r_sr    <= {sum, r_sr[N-1:1]};
      carry   <= (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
      cin_msb <= carry;
    end
  end

  assign Result   = r_sr;
  assign CarryOut = carry;
  assign Overflow = carry ^ cin_msb;

endmodule

// File: rtl/serial_alu_sched.sv
// rtl/serial_alu_sched.sv - round-robin scheduler sharing one serial add/subtract datapath
module serial_alu_sched
  import serial_alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [1:0]   ReqValid,
  input  logic [1:0]   ReqOp,
  input  logic [N-1:0] ReqA0,
  input  logic [N-1:0] ReqB0,
  input  logic [N-1:0] ReqA1,
  input  logic [N-1:0] ReqB1,
  output logic [1:0]   ReqReady,
  output logic [N-1:0] Result,
  output logic         CarryOut,
  output logic         Overflow,
  output logic         ResultId,
  output logic         ResultValid,
  input  logic         ResultAck
);

  localparam int CW = $clog2(N + 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic          ptr;
  logic          grant;
  logic          load;
  logic          shift;
  logic          op_sub;
  logic [N-1:0]  a_sel;
  logic [N-1:0]  b_sel;

  assign a_sel  = grant ? ReqA1 : ReqA0;
  assign b_sel  = grant ? ReqB1 : ReqB0;
  assign op_sub = ((grant ? ReqOp[1] : ReqOp[0]) == OP_SUB);

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, grant and datapath controls; ready is gated by Reset so it reads 0 during reset.
  always_comb begin
    state_nxt = state;
    ReqReady  = 2'b00;
    grant     = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        grant = (&ReqValid) ? ptr : ~ReqValid[0];
        if (|ReqValid && !Reset) begin
          ReqReady[grant] = 1'b1;
          load            = 1'b1;
          state_nxt       = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (count == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (ResultAck) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift counter, round-robin pointer, result owner and result-valid flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count       <= '0;
      ptr         <= 1'b0;
      ResultId    <= 1'b0;
      ResultValid <= 1'b0;
    end else begin
      if (load) begin
        count    <= CW'(N);
        ptr      <= ~grant;
        ResultId <= grant;
      end
      if (shift) begin
        count <= count - CW'(1);
        if (count == CW'(1)) ResultValid <= 1'b1;
      end
      if (state == DONE && ResultAck) ResultValid <= 1'b0;
    end
  end

  serial_addsub_dp #(.N(N)) u_dp (
    .Clock    (Clock),
    .Reset    (Reset),
    .Load     (load),
    .Shift    (shift),
    .OpSub    (op_sub),
    .A        (a_sel),
    .B        (b_sel),
    .Result   (Result),
    .CarryOut (CarryOut),
    .Overflow (Overflow)
  );

endmodule

// File: tb/tb_serial_alu_sched.sv
// tb/tb_serial_alu_sched.sv - scoreboard bench for the serial add/subtract scheduler
module tb_serial_alu_sched;
  import serial_alu_pkg::*;

  localparam int N = 8;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [1:0]   ReqValid;
  logic [1:0]   ReqOp;
  logic [N-1:0] ReqA0, ReqB0, ReqA1, ReqB1;
  logic [1:0]   ReqReady;
  logic [N-1:0] Result;
  logic         CarryOut, Overflow, ResultId, ResultValid;
  logic         ResultAck;

  typedef struct packed {
    logic [N-1:0] res;
    logic         cy;
    logic         ov;
    logic         id;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  serial_alu_sched #(.N(N)) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqOp(ReqOp),
    .ReqA0(ReqA0), .ReqB0(ReqB0), .ReqA1(ReqA1), .ReqB1(ReqB1),
    .ReqReady(ReqReady), .Result(Result), .CarryOut(CarryOut), .Overflow(Overflow),
    .ResultId(ResultId), .ResultValid(ResultValid), .ResultAck(ResultAck)
  );

  always #5 Clock = ~Clock;

  function automatic exp_t model(input logic id, input logic op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t       m;
    logic [N:0] full;
    logic [N-1:0] bx;
    bx    = (op == OP_SUB) ? ~b : b;
    full  = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, op};
    m.res = full[N-1:0];
    m.cy  = full[N];
    m.ov  = (a[N-1] == bx[N-1]) && (full[N-1] != a[N-1]);
    m.id  = id;
    return m;
  endfunction

  // Raise ReqValid[r], wait for the grant, push the expectation, pass the accept edge.
  task automatic issue(input logic r, input logic op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit push, input bit keep);
    int w;
    ReqValid[r] = 1'b1;
    ReqOp[r]    = op;
    if (r) begin ReqA1 = a; ReqB1 = b; end
    else   begin ReqA0 = a; ReqB0 = b; end
    #1;
    w = 0;
    while (!ReqReady[r] && w < 40) begin
      @(negedge Clock); #1; w++;
    end
    if (!ReqReady[r]) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout req%0d: ReqReady=%b, required bit %0d set", r, ReqReady, r);
    end
    if (push) sb.push_back(model(r, op, a, b));
    @(negedge Clock);
    if (!keep) ReqValid[r] = 1'b0;
  endtask

  // Count edges after the accept edge until ResultValid rises (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!ResultValid && lat < 40) begin
      @(negedge Clock); lat++;
    end
    if (!ResultValid) begin
      n_cmp++; n_bad++;
      $display("FAIL result_timeout: ResultValid=%b after %0d edges, required 1", ResultValid, lat);
    end
  endtask

  // Pop the expected result, compare it, hold it for 'hold' cycles, then acknowledge.
  task automatic take_result(input string name, input int hold);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: result with empty scoreboard, Result=%h", name, Result);
      return;
    end
    e = sb.pop_front();
    n_cmp++; if (Result !== e.res) begin n_bad++; $display("FAIL %s result: got %h, required %h", name, Result, e.res); end
    n_cmp++; if (CarryOut !== e.cy) begin n_bad++; $display("FAIL %s carry: got %b, required %b", name, CarryOut, e.cy); end
    n_cmp++; if (Overflow !== e.ov) begin n_bad++; $display("FAIL %s overflow: got %b, required %b", name, Overflow, e.ov); end
    n_cmp++; if (ResultId !== e.id) begin n_bad++; $display("FAIL %s id: got %b, required %b", name, ResultId, e.id); end
    for (int i = 0; i < hold; i++) begin
      @(negedge Clock); #1;
      n_cmp++;
      if ({ResultValid, ReqReady, Result} !== {1'b1, 2'b00, e.res}) begin
        n_bad++;
        $display("FAIL %s hold%0d: valid/ready/result=%b/%b/%h, required 1/00/%h", name, i, ResultValid, ReqReady, Result, e.res);
      end
    end
    ResultAck = 1'b1;
    @(negedge Clock);
    ResultAck = 1'b0;
    n_cmp++;
    if (ResultValid !== 1'b0) begin n_bad++; $display("FAIL %s ack: ResultValid=%b, required 0", name, ResultValid); end
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_reset();
    ReqValid = 2'b11; ReqOp = 2'b00; ResultAck = 1'b0;
    ReqA0 = 8'h11; ReqB0 = 8'h22; ReqA1 = 8'h33; ReqB1 = 8'h44;
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    #1;
    n_cmp++;
    if ({ReqReady, Result, CarryOut, Overflow, ResultId, ResultValid} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b res=%h c=%b v=%b id=%b rv=%b, required all 0",
               ReqReady, Result, CarryOut, Overflow, ResultId, ResultValid);
    end
    ReqValid = 2'b00;
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_add();
    int lat;
    issue(1'b0, OP_ADD, 8'h35, 8'h0C, 1'b1, 1'b1);
    #1;
    n_cmp++;
    if (ReqReady !== 2'b00) begin n_bad++; $display("FAIL add_ready_pulse: ReqReady=%b, required 00", ReqReady); end
    @(negedge Clock);
    ReqValid[0] = 1'b0;
    wait_done(lat);
    lat = lat + 1;
    n_cmp++;
    if (lat !== N) begin n_bad++; $display("FAIL add_latency: got %0d edges, required %0d", lat, N); end
    take_result("add", 0);
  endtask

  task automatic test_sub_overflow();
    int lat;
    issue(1'b1, OP_SUB, 8'h05, 8'h07, 1'b1, 1'b0);
    wait_done(lat);
    take_result("sub_borrow", 0);
    issue(1'b1, OP_ADD, 8'h7F, 8'h01, 1'b1, 1'b0);
    wait_done(lat);
    take_result("add_ovf", 0);
    issue(1'b0, OP_SUB, 8'h80, 8'h01, 1'b1, 1'b0);
    wait_done(lat);
    take_result("sub_ovf", 0);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic r;
    logic [1:0] exp_rdy;
    apply_reset();
    ReqOp = 2'b10;
    ReqA0 = 8'h10; ReqB0 = 8'h01; ReqA1 = 8'h20; ReqB1 = 8'h03;
    ReqValid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      r = k[0];
      exp_rdy = r ? 2'b10 : 2'b01;
      #1;
      n_cmp++;
      if (ReqReady !== exp_rdy) begin n_bad++; $display("FAIL rr_grant%0d: ReqReady=%b, required %b", k, ReqReady, exp_rdy); end
      sb.push_back(model(r, ReqOp[r], r ? ReqA1 : ReqA0, r ? ReqB1 : ReqB0));
      @(negedge Clock);
      if (r) begin ReqA1 = ReqA1 + 8'h31; ReqB1 = ReqB1 + 8'h17; end
      else   begin ReqA0 = ReqA0 + 8'h45; ReqB0 = ReqB0 + 8'h29; end
      wait_done(lat);
      take_result($sformatf("rr%0d", k), 0);
    end
    ReqValid = 2'b00;
    @(negedge Clock);
  endtask

  task automatic test_hold_ack();
    int lat;
    issue(1'b0, OP_ADD, 8'hA5, 8'h3C, 1'b1, 1'b0);
    wait_done(lat);
    ReqValid[1] = 1'b1; ReqOp[1] = OP_SUB; ReqA1 = 8'h40; ReqB1 = 8'h41;
    take_result("hold", 5);
    #1;
    n_cmp++;
    if (ReqReady !== 2'b10) begin n_bad++; $display("FAIL post_ack_grant: ReqReady=%b, required 10", ReqReady); end
    issue(1'b1, OP_SUB, 8'h40, 8'h41, 1'b1, 1'b0);
    wait_done(lat);
    take_result("after_hold", 0);
  endtask

  task automatic test_reset_abort();
    int lat;
    issue(1'b0, OP_ADD, 8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    #1;
    n_cmp++;
    if ({ReqReady, Result, CarryOut, Overflow, ResultId, ResultValid} !== '0) begin
      n_bad++;
      $display("FAIL abort_outputs: rdy=%b res=%h c=%b v=%b id=%b rv=%b, required all 0",
               ReqReady, Result, CarryOut, Overflow, ResultId, ResultValid);
    end
    @(negedge Clock);
    Reset = 1'b0;
    repeat (12) @(negedge Clock);
    n_cmp++;
    if (ResultValid !== 1'b0) begin n_bad++; $display("FAIL abort_no_result: ResultValid=%b, required 0", ResultValid); end
    issue(1'b0, OP_ADD, 8'hFF, 8'h01, 1'b1, 1'b0);
    wait_done(lat);
    take_result("after_abort", 0);
  endtask

  task automatic test_ignored_inputs();
    int lat;
    ResultAck = 1'b1;
    @(negedge Clock);
    ResultAck = 1'b0;
    #1;
    n_cmp++;
    if ({ResultValid, ReqReady} !== 3'b000) begin n_bad++; $display("FAIL idle_ack: valid/ready=%b/%b, required 0/00", ResultValid, ReqReady); end
    issue(1'b0, OP_SUB, 8'hC8, 8'h64, 1'b1, 1'b0);
    ReqOp[1] = OP_ADD; ReqA1 = 8'h0F; ReqB1 = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      ResultAck   = ~i[0];
      ReqValid[1] = ~i[0];
      #1;
      n_cmp++;
      if (ReqReady !== 2'b00) begin n_bad++; $display("FAIL shift_ready%0d: ReqReady=%b, required 00", i, ReqReady); end
      @(negedge Clock);
    end
    ResultAck   = 1'b0;
    ReqValid[1] = 1'b1;
    wait_done(lat);
    lat = lat + 4;
    n_cmp++;
    if (lat !== N) begin n_bad++; $display("FAIL shift_ack_latency: got %0d edges, required %0d", lat, N); end
    take_result("ignored", 0);
    issue(1'b1, OP_ADD, 8'h0F, 8'hF0, 1'b1, 1'b0);
    wait_done(lat);
    take_result("waiter", 0);
  endtask

  initial begin
    Reset = 1'b0;
    ReqValid = 2'b00; ReqOp = 2'b00; ResultAck = 1'b0;
    ReqA0 = '0; ReqB0 = '0; ReqA1 = '0; ReqB1 = '0;
    @(negedge Clock);
    test_reset();
    test_add();
    test_sub_overflow();
    test_back_to_back();
    test_hold_ack();
    test_reset_abort();
    test_ignored_inputs();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover: %0d entries, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
